// File: rtl/usb_rx_phy.sv
// rtl/usb_rx_phy.sv - USB 1.x receive PHY: sync, clock recovery, NRZI decode, SYNC/EOP detect, unstuff
module usb_rx_phy #(
  parameter int CLKS_PER_BIT   = 4,
  parameter int FULL_SPEED     = 1,
  parameter int DATA_BIT_WIDTH = 8,
  parameter int RESET_CLKS     = 120
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      usb_rx_dp_i,
  input  logic                      usb_rx_dm_i,
  output logic                      rx_active_o,
  output logic                      rx_valid_o,
  output logic [DATA_BIT_WIDTH-1:0] rx_data_o,
  output logic                      rx_eop_o,
  output logic                      rx_error_o,
  output logic                      sync_det_o,
  output logic [1:0]                line_state_o,
  output logic                      usb_reset_o
);

  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BIT_WIDTH + 1);
  localparam int RW = $clog2(RESET_CLKS + 1);

  localparam logic [1:0] LS_J   = (FULL_SPEED != 0) ? 2'b10 : 2'b01;
  localparam logic [1:0] LS_K   = (FULL_SPEED != 0) ? 2'b01 : 2'b10;
  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_SE1 = 2'b11;

  localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(CLKS_PER_BIT / 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BIT_WIDTH - 1);
  localparam logic [RW-1:0] RST_LAST  = RW'(RESET_CLKS - 1);
  localparam logic [RW-1:0] RST_MAX   = RW'(RESET_CLKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP,
    S_ERR
  } state_t;

  logic [1:0]                meta_q;
  logic [1:0]                sync_q;
  logic [1:0]                prev_ls_q;
  logic [PW-1:0]             phase_q;
  logic [PW-1:0]             phase_d;
  logic                      sample_stb;
  logic [RW-1:0]             se0_cnt_q;
  logic                      usb_reset_q;

  state_t                    state_q;
  logic [2:0]                sync_cnt_q;
  logic [2:0]                ones_q;
  logic [BW-1:0]             bit_cnt_q;
  logic                      prev_k_q;
  logic                      se0_more_q;
  logic                      idle_j_q;
  logic [DATA_BIT_WIDTH-1:0] data_q;
  logic                      active_q;
  logic                      valid_q;
  logic                      eop_q;
  logic                      err_q;
  logic                      sync_det_q;

  logic                      cur_j;
  logic                      cur_k;
  logic                      dec_bit;

  // Two-flop synchroniser per pad, plus one more stage to spot line transitions
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q    <= 2'b00;
      sync_q    <= 2'b00;
      prev_ls_q <= 2'b00;
    end else begin
      meta_q    <= {usb_rx_dp_i, usb_rx_dm_i};
      sync_q    <= meta_q;
      prev_ls_q <= sync_q;
    end
  end

  // Phase counter restarts on each transition so the sample lands mid-bit despite jitter
  always_comb begin
    phase_d = phase_q + 1'b1;
    if ((sync_q != prev_ls_q) || (phase_q == PH_LAST)) begin
      phase_d = '0;
    end
    sample_stb = (phase_d == PH_SAMPLE);
  end

  // Register the recovered phase
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Bus reset: count SE0 clocks, saturating, independent of the packet FSM
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      se0_cnt_q   <= '0;
      usb_reset_q <= 1'b0;
    end else if (sync_q == LS_SE0) begin
      if (se0_cnt_q != RST_MAX) begin
        se0_cnt_q <= se0_cnt_q + 1'b1;
      end
      if (se0_cnt_q >= RST_LAST) begin
        usb_reset_q <= 1'b1;
      end
    end else begin
      se0_cnt_q   <= '0;
      usb_reset_q <= 1'b0;
    end
  end

  assign cur_j   = (sync_q == LS_J);
  assign cur_k   = (sync_q == LS_K);
  // NRZI: no change between samples decodes as 1
  assign dec_bit = (cur_k == prev_k_q);

  // Packet FSM: SYNC match, unstuffing, word assembly, EOP and error handling
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      sync_cnt_q <= '0;
      ones_q     <= '0;
      bit_cnt_q  <= '0;
      prev_k_q   <= 1'b0;
      se0_more_q <= 1'b0;
      idle_j_q   <= 1'b0;
      data_q     <= '0;
      active_q   <= 1'b0;
      valid_q    <= 1'b0;
      eop_q      <= 1'b0;
      err_q      <= 1'b0;
      sync_det_q <= 1'b0;
    end else begin
      valid_q    <= 1'b0;
      eop_q      <= 1'b0;
      err_q      <= 1'b0;
      sync_det_q <= 1'b0;
      if (sample_stb) begin
        case (state_q)
          S_IDLE: begin
            prev_k_q <= 1'b0;
            if (cur_k) begin
              state_q    <= S_SYNC;
              sync_cnt_q <= 3'd1;
              prev_k_q   <= 1'b1;
            end
          end
          S_SYNC: begin
            prev_k_q <= cur_k;
            if (!cur_j && !cur_k) begin
              state_q <= S_IDLE;
            end else if (sync_cnt_q != 3'd7) begin
              if (dec_bit) begin
                state_q <= S_IDLE;
              end else begin
                sync_cnt_q <= sync_cnt_q + 3'd1;
              end
            end else if (dec_bit) begin
              state_q    <= S_DATA;
              sync_det_q <= 1'b1;
              active_q   <= 1'b1;
              ones_q     <= 3'd1;
              bit_cnt_q  <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_DATA: begin
            if (sync_q == LS_SE0) begin
              state_q    <= S_EOP;
              se0_more_q <= 1'b0;
            end else if (sync_q == LS_SE1) begin
              state_q  <= S_ERR;
              err_q    <= 1'b1;
              active_q <= 1'b0;
              idle_j_q <= 1'b0;
            end else begin
              prev_k_q <= cur_k;
              if (ones_q == 3'd6) begin
                if (dec_bit) begin
                  state_q  <= S_ERR;
                  err_q    <= 1'b1;
                  active_q <= 1'b0;
                  idle_j_q <= 1'b0;
                end else begin
                  ones_q <= '0;
                end
              end else begin
                ones_q <= dec_bit ? ones_q + 3'd1 : 3'd0;
                data_q <= DATA_BIT_WIDTH'({dec_bit, data_q} >> 1);
                if (bit_cnt_q == BIT_LAST) begin
                  bit_cnt_q <= '0;
                  valid_q   <= 1'b1;
                end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                end
              end
            end
          end
          S_EOP: begin
            if (sync_q == LS_SE0) begin
              se0_more_q <= 1'b1;
            end else if (cur_j && se0_more_q) begin
              eop_q    <= 1'b1;
              err_q    <= (bit_cnt_q != '0);
              active_q <= 1'b0;
              prev_k_q <= 1'b0;
              state_q  <= S_IDLE;
            end else begin
              state_q  <= S_ERR;
              err_q    <= 1'b1;
              active_q <= 1'b0;
              idle_j_q <= 1'b0;
            end
          end
          S_ERR: begin
            if (cur_j) begin
              idle_j_q <= 1'b1;
              if (idle_j_q) begin
                state_q  <= S_IDLE;
                prev_k_q <= 1'b0;
              end
            end else begin
              idle_j_q <= 1'b0;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign rx_active_o  = active_q;
  assign rx_valid_o   = valid_q;
  assign rx_data_o    = data_q;
  assign rx_eop_o     = eop_q;
  assign rx_error_o   = err_q;
  assign sync_det_o   = sync_det_q;
  assign line_state_o = sync_q;
  assign usb_reset_o  = usb_reset_q;

endmodule

// File: doc/usb_rx_phy.md
Name: usb_rx_phy

Overview:
- Parametrised USB 1.x receive PHY: NRZI decode, oversampled clock recovery, SYNC detect, bit-unstuffing, EOP and bus-reset detect, serial-to-parallel byte assembly.
- Speed (low/full) and oversampling ratio are set by parameters.
- Sits between the D+/D- pads and the packet decoder; delivers one byte per valid pulse with no backpressure.

Parameters:
- CLKS_PER_BIT, 4, sys clocks per USB bit (>=4; 48MHz FS=4, 6MHz LS... any integer >=4)
- FULL_SPEED, 1, 1: J=(D+,D-)=10, K=01; 0: low speed, J=01, K=10
- DATA_BIT_WIDTH, 8, output word width (multiple of 8 not required; word completes every DATA_BIT_WIDTH unstuffed bits)
- RESET_CLKS, 120, consecutive SE0 clocks that flag bus reset (2.5us at 48MHz)

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_ni  in  1  synchronous active-low reset, sampled on rising edge of clk_i
- usb_rx_dp_i  in  1  raw D+ (asynchronous)
- usb_rx_dm_i  in  1  raw D- (asynchronous)
- rx_active_o  out  1  high from SYNC detected until EOP/error
- rx_valid_o  out  1  one-clock pulse, rx_data_o valid
- rx_data_o  out  DATA_BIT_WIDTH  received word, first-received bit in LSB
- rx_eop_o  out  1  one-clock pulse on valid EOP
- rx_error_o  out  1  one-clock pulse: stuff error, SE1, or EOP with partial word
- sync_det_o  out  1  one-clock pulse when SYNC completes
- line_state_o  out  2  synchronised {D+,D-}
- usb_reset_o  out  1  level, high while SE0 lasts >= RESET_CLKS

Behaviour:
- Reset: all outputs 0, rx_data_o 0, FSM IDLE, counters 0; reset mid-packet aborts with no eop/error pulse.
- Input sync: 2-FF per line; line_state_o = second stage (2 clk latency).
- Clock recovery: phase counter 0..CLKS_PER_BIT-1. Reloads to 0 on any line_state change, else increments and wraps. Bit sampled when counter == CLKS_PER_BIT/2 (integer divide).
- NRZI: sampled J/K equal to previous sample -> bit 1; different -> bit 0. Previous sample is initialised to J in IDLE.
- FSM states: IDLE, SYNC, DATA, EOP, ERR.
  - IDLE: first K sample -> SYNC.
  - SYNC: requires decoded pattern 0000000 then 1 (KJKJKJKK). On the final K, pulse sync_det_o, assert rx_active_o, go to DATA. Any mismatch or SE0 -> IDLE with no error.
  - DATA: decoded bits shift into rx_data_o from the MSB side. After DATA_BIT_WIDTH unstuffed bits, rx_valid_o pulses the next clk and the bit counter wraps to 0.
  - DATA, SE0 sample -> EOP.
  - DATA, SE1 sample -> ERR.
- Bit unstuff: ones counter counts consecutive decoded 1s (SYNC's trailing 1 counts). After six 1s the next bit is discarded if 0 and the counter clears. If that bit is 1 -> ERR (stuff error). A stuffed bit never increments the bit counter.
- EOP: needs at least one more SE0 sample, then a J sample. If the bit counter is 0: pulse rx_eop_o, drop rx_active_o the same clk, go to IDLE. If the bit counter is nonzero, pulse both rx_eop_o and rx_error_o. A K after SE0, or a single SE0 sample followed by J/K -> ERR.
- ERR: pulse rx_error_o, drop rx_active_o, wait for J held for 2 bit times (idle) -> IDLE.
- usb_reset_o: SE0 counter saturates at RESET_CLKS; sets when the count reaches RESET_CLKS, clears on first non-SE0 clk. Independent of FSM state; a reset SE0 during DATA also runs the EOP/ERR path.
- Simultaneous: rx_valid_o for the last word and rx_eop_o are never in the same clk (EOP needs >=2 bit times of SE0).

Test Plan:
- FS, CLKS_PER_BIT=4: SYNC + bytes 0xA5, 0x3C + SE0x2 + J -> sync_det_o 1 pulse; rx_valid_o twice with 0xA5 then 0x3C; rx_eop_o 1 pulse; rx_error_o never.
- Payload 0xFF,0xFF with stuffed 0 after each six 1s -> two valid pulses of 0xFF, no error. Same stream with the stuffed bit omitted -> rx_error_o pulse, rx_active_o low, no further valid.
- Bit period jitter ±1 clk every bit over a 4-byte packet -> all bytes correct. LS mode (FULL_SPEED=0, swapped J/K) -> same bytes.
- EOP after 12 data bits -> one valid pulse, then rx_eop_o and rx_error_o together. SE1 mid-byte -> error pulse, return to IDLE after 2 bit times of J.
- SE0 held 130 clks with RESET_CLKS=120 -> usb_reset_o rises at clk 120 (plus sync latency), falls one clk after J.
- rst_ni low mid-byte -> next clk all outputs 0; following clean packet decoded correctly.
